uart_tx_scheduler: RTL and testbench

//  Shares one UART transmit line between N_REQ byte requesters using round-robin arbitration.

---
 rtl/uart_tx_scheduler.sv | 148 ++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter that shares one 8N1 UART transmit
// line between N_REQ byte requesters, paced by the TX baud tick, and owns the
// baud-rate code driven into the baud generator (changed only between frames).
module uart_tx_scheduler #(
  parameter int         N_REQ        = 4,
  parameter int         DATA_W       = 8,
  parameter logic [1:0] BAUD_SEL_RST = 2'b01,
  localparam int        IW           = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int        BW           = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     baud_tick,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     cfg_valid,
  input  logic [1:0]               cfg_baud_sel,
  output logic [1:0]               baud_sel,
  output logic                     tx,
  output logic                     tx_busy,
  output logic [IW-1:0]            grant_id
);

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state;
  logic [IW-1:0]     rr_ptr;
  logic              cfg_pend;
  logic [1:0]        cfg_code;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] shift_nxt;
  logic [BW-1:0]     bit_idx;

  logic              grant_found;
  logic [IW-1:0]     grant_idx;
  logic              cfg_now;
  logic [1:0]        cfg_now_code;
  logic              accept;

  // Round-robin pick: first valid requester after the last granted one, wrapping.
  always_comb begin
    int            sum;
    logic [IW-1:0] cand;
    sum         = 0;
    cand        = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      sum = int'(rr_ptr) + k;
      if (sum >= N_REQ) sum = sum - N_REQ;
      cand = IW'(sum);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // A strobe arriving in an IDLE cycle is applied immediately and beats any grant.
  always_comb begin
    cfg_now      = cfg_valid | cfg_pend;
    cfg_now_code = cfg_valid ? cfg_baud_sel : cfg_code;
    accept       = !reset && (state == IDLE) && !cfg_now && grant_found;
    shift_nxt    = shift >> 1;
    req_ready    = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  // Frame FSM with registered line, busy flag, grant index and baud code.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      grant_id <= '0;
      baud_sel <= BAUD_SEL_RST;
      cfg_pend <= 1'b0;
      rr_ptr   <= IW'(N_REQ - 1);
      bit_idx  <= '0;
    end else begin
      if (cfg_valid) begin
        cfg_pend <= 1'b1;
        cfg_code <= cfg_baud_sel;
      end
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (cfg_now) begin
            baud_sel <= cfg_now_code;
            cfg_pend <= 1'b0;
          end else if (grant_found) begin
            shift    <= req_data[grant_idx*DATA_W +: DATA_W];
            grant_id <= grant_idx;
            rr_ptr   <= grant_idx;
            tx_busy  <= 1'b1;
            state    <= ALIGN;
          end
        end
        // Waiting for a fresh tick guarantees the start bit lasts a full period.
        ALIGN: begin
          if (baud_tick) begin
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (baud_tick) begin
            tx      <= shift[0];
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (baud_tick) begin
            shift <= shift_nxt;
            if (bit_idx == BW'(DATA_W - 1)) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx      <= shift_nxt[0];
              bit_idx <= bit_idx + BW'(1);
            end
          end
        end
        STOP: begin
          if (baud_tick) begin
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: frame-level reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_uart_tx_scheduler;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TP = 8;  // clock cycles per baud tick

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            baud_tick = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            cfg_valid = 1'b0;
  logic [1:0]      cfg_baud_sel = 2'b00;
  logic [1:0]      baud_sel;
  logic            tx;
  logic            tx_busy;
  logic [1:0]      grant_id;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.N_REQ(N), .DATA_W(DW), .BAUD_SEL_RST(2'b01)) dut (
    .clk(clk), .reset(reset), .baud_tick(baud_tick),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .cfg_valid(cfg_valid), .cfg_baud_sel(cfg_baud_sel), .baud_sel(baud_sel),
    .tx(tx), .tx_busy(tx_busy), .grant_id(grant_id)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- reference model (frame level) ----------------
  // A frame is 10 line bits {stop, data, start}; after acceptance the first
  // tick only aligns, tick k (1..10) puts bit k-1 on the line, tick 11 ends it.
  bit        m_busy = 1'b0;
  int        m_ticks = 0;
  logic [9:0] m_frame = 10'h3FF;
  int        m_grant = 0;
  int        m_rr = N - 1;
  logic [1:0] m_baud = 2'b01;
  bit        m_pend = 1'b0;
  logic [1:0] m_code = 2'b00;
  int        cyc = 0;
  int        grant_q[$];
  int        gcyc_q[$];

  function automatic int m_pick();
    for (int k = 1; k <= N; k++) begin
      if (req_valid[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] m_byte(input int i);
    return req_data[i*DW +: DW];
  endfunction

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    r = '0;
    if (!reset && !m_busy && !(cfg_valid || m_pend) && m_pick() >= 0) r[m_pick()] = 1'b1;
    return r;
  endfunction

  function automatic logic m_tx();
    if (!m_busy || m_ticks == 0) return 1'b1;
    return m_frame[m_ticks-1];
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_busy  <= 1'b0;
      m_ticks <= 0;
      m_grant <= 0;
      m_rr    <= N - 1;
      m_baud  <= 2'b01;
      m_pend  <= 1'b0;
    end else begin
      if (cfg_valid) begin
        m_pend <= 1'b1;
        m_code <= cfg_baud_sel;
      end
      if (!m_busy) begin
        if (cfg_valid || m_pend) begin
          m_baud <= cfg_valid ? cfg_baud_sel : m_code;
          m_pend <= 1'b0;
        end else if (m_pick() >= 0) begin
          m_busy  <= 1'b1;
          m_ticks <= 0;
          m_frame <= {1'b1, m_byte(m_pick()), 1'b0};
          m_grant <= m_pick();
          m_rr    <= m_pick();
          grant_q.push_back(m_pick());
          gcyc_q.push_back(cyc);
        end
      end else if (baud_tick) begin
        if (m_ticks == 10) m_busy <= 1'b0;
        else m_ticks <= m_ticks + 1;
      end
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en)
      check("cycle_compare",
            {22'd0, tx, tx_busy, grant_id, baud_sel, req_ready},
            {22'd0, m_tx(), m_busy, 2'(m_grant), m_baud, m_ready()});
  end

  // ---------------- stimulus ----------------
  int           tick_cnt = 0;
  logic [N-1:0] hold = '0;
  logic [N-1:0] last_ready = '0;

  // One clock cycle: capture ready, retire consumed bytes, pulse strobes/ticks.
  task automatic cycle();
    @(negedge clk);
    last_ready = req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (last_ready[i]) begin
        if (hold[i]) req_data[i*DW +: DW] = req_data[i*DW +: DW] + 8'd1;
        else req_valid[i] = 1'b0;
      end
    end
    cfg_valid = 1'b0;
    tick_cnt++;
    baud_tick = (tick_cnt % TP) == 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    cycle();
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_ready", req_ready, 0);
    check("rst_baud", baud_sel, 2'b01);
    check("rst_grant", grant_id, 0);
    reset = 1'b0;
  endtask

  task automatic wait_idle();
    for (int g = 0; g < 3000 && tx_busy; g++) cycle();
    check("wait_idle", tx_busy, 0);
  endtask

  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    for (int g = 0; g < 40 * TP && k < n; g++) begin
      cycle();
      if (baud_tick) k++;
    end
    check("wait_ticks", k, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n;
    int base;
    logic [9:0] cap;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};

    cycle();
    chk_en = 1'b1;

    // Test 1: reset
    do_reset();

    // Test 2: single byte 0xA5 from requester 2
    for (int g = 0; g < 2 * TP && baud_tick; g++) cycle();
    req_data[2*DW +: DW] = 8'hA5;
    req_valid[2] = 1'b1;
    cycle();
    check("t2_ready", last_ready, 4'b0100);
    k = 0;
    cap = '0;
    for (int g = 0; g < 200 && k < 11; g++) begin
      if (baud_tick) begin
        k++;
        if (k >= 2) cap = {cap[8:0], tx};
        if (k == 11) check("t2_busy_at_stop_tick", tx_busy, 1);
      end
      if (k < 11) cycle();
      if (g == 0) check("t2_ready_once", last_ready, 0);
    end
    check("t2_tick_count", k, 11);
    check("t2_bits", cap, 10'b0101001011);
    check("t2_grant", grant_id, 2);
    cycle();
    check("t2_busy_drop", tx_busy, 0);

    // Test 6: tick coincident with acceptance is not counted
    for (int g = 0; g < 2 * TP && !baud_tick; g++) cycle();
    check("t6_on_tick", baud_tick, 1);
    req_data[0 +: DW] = 8'h3C;
    req_valid[0] = 1'b1;
    n = 0;
    for (int g = 0; g < 100; g++) begin
      cycle();
      n++;
      if (tx === 1'b0) break;
    end
    check("t6_start_delay", n, TP + 1);
    wait_idle();

    // Test 3: all four requesters continuously valid
    do_reset();
    req_data = {8'h40, 8'h30, 8'h20, 8'h10};
    hold = 4'hF;
    req_valid = 4'hF;
    base = grant_q.size();
    for (int g = 0; g < 1500 && grant_q.size() < base + 5; g++) cycle();
    req_valid = '0;
    hold = '0;
    check("t3_grant_count", grant_q.size() - base, 5);
    for (int i = 0; i < 5; i++) begin
      if (grant_q.size() > base + i) check($sformatf("t3_order_%0d", i), grant_q[base+i], exp_order[i]);
    end
    if (gcyc_q.size() > base + 3) check("t3_frame_spacing", gcyc_q[base+3] - gcyc_q[base+2], 11 * TP);
    wait_idle();

    // Test 4: config strobe mid-frame is deferred to IDLE and beats a grant
    req_data[1*DW +: DW] = 8'h5A;
    req_valid[1] = 1'b1;
    wait_ticks(4);
    cfg_baud_sel = 2'b11;
    cfg_valid = 1'b1;
    req_data[2*DW +: DW] = 8'hC3;
    req_valid[2] = 1'b1;
    cycle();
    check("t4_hold_busy", baud_sel, 2'b01);
    wait_idle();
    check("t4_not_yet", baud_sel, 2'b01);
    cycle();
    check("t4_cfg_first_ready", last_ready, 0);
    check("t4_applied", baud_sel, 2'b11);
    cycle();
    check("t4_grant_next", last_ready, 4'b0100);
    wait_ticks(3);
    cfg_baud_sel = 2'b00;
    cfg_valid = 1'b1;
    cycle();
    cycle();
    cfg_baud_sel = 2'b10;
    cfg_valid = 1'b1;
    cycle();
    check("t4_two_strobes_held", baud_sel, 2'b11);
    wait_idle();
    cycle();
    check("t4_last_wins", baud_sel, 2'b10);

    // Test 5: reset during DATA bit 3 aborts the frame
    hold[1] = 1'b1;
    req_data[1*DW +: DW] = 8'h77;
    req_valid[1] = 1'b1;
    base = grant_q.size();
    for (int g = 0; g < 20 && grant_q.size() == base; g++) cycle();
    k = 0;
    for (int g = 0; g < 100 && k < 5; g++) begin
      if (baud_tick) k++;
      if (k < 5) cycle();
    end
    cycle();
    cycle();
    check("t5_busy_before", tx_busy, 1);
    reset = 1'b1;
    cycle();
    check("t5_tx_after_reset", tx, 1);
    check("t5_busy_after_reset", tx_busy, 0);
    reset = 1'b0;
    base = grant_q.size();
    for (int g = 0; g < 20 && grant_q.size() == base; g++) cycle();
    check("t5_regrant_seen", grant_q.size() - base, 1);
    if (grant_q.size() > 0) check("t5_regrant_id", grant_q[grant_q.size()-1], 1);
    hold[1] = 1'b0;
    req_valid[1] = 1'b0;
    wait_idle();
    cycle();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
